// File: rtl/noc_outport_arbiter.sv
// -----------------------------------------------------------------------------
// noc_outport_arbiter
//   Output-port controller for one router output of the mesh NoC. Five input
//   FIFOs (0=N, 1=E, 2=S, 3=W, 4=Local) share the output through round-robin
//   arbitration with wormhole locking: a grant is held for PKT_LEN reads and
//   is never preempted. Downstream flow control is credit based.
//
//   Optional feature macro: STALL_WATCHDOG_EN
//     When defined, a stall watchdog aborts a grant that has made no progress
//     for WD_LIMIT cycles and raises the sticky o_wd_err flag.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   i_req[4:0]    input i has a packet head routed to this output
//   i_avail[4:0]  input FIFO i holds at least one unread flit
//   i_in_flit     FIFO data buses, input i on bits [8i+7:8i]
//   i_credit_ret  one-cycle pulse: downstream freed one slot
//   o_rd[4:0]     one-hot FIFO read strobe (combinational)
//   o_out_flit    forwarded flit (registered)
//   o_out_valid   o_out_flit valid this cycle (registered)
//   o_gnt[4:0]    one-hot current grant, 0 when idle (registered)
//   o_busy        1 while a packet transfer is in progress
//   o_credits     current downstream credit count
//   o_cr_err      sticky: credit returned while already at full credits
//   o_wd_err      sticky watchdog flag (0 when the watchdog is compiled out)
// -----------------------------------------------------------------------------
module noc_outport_arbiter #(
  parameter int PKT_LEN  = 4,
  parameter int CREDITS  = 8
`ifdef STALL_WATCHDOG_EN
  , parameter int WD_LIMIT = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_req,
  input  logic [4:0]  i_avail,
  input  logic [39:0] i_in_flit,
  input  logic        i_credit_ret,
  output logic [4:0]  o_rd,
  output logic [7:0]  o_out_flit,
  output logic        o_out_valid,
  output logic [4:0]  o_gnt,
  output logic        o_busy,
  output logic [3:0]  o_credits,
  output logic        o_cr_err,
  output logic        o_wd_err
);

  localparam logic [3:0] LP_LAST = 4'(PKT_LEN - 1);
  localparam logic [3:0] LP_CRED = 4'(CREDITS);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_gnt;
  logic [2:0]  r_gidx;
  logic [2:0]  r_ptr;
  logic [3:0]  r_cnt;
  logic [3:0]  r_credits;
  logic        r_cr_err;
  logic [2:0]  r_sel;
  logic        r_sel_vld;
  logic [7:0]  r_out_flit;
  logic        r_out_valid;
  logic [4:0]  w_rd;
  logic [2:0]  w_pick;
  logic        w_read;
  logic        w_tail;
  logic        w_wd_fire;

  // First requester at or above ptr, wrapping modulo 5.
  function automatic logic [2:0] rr_pick(input logic [4:0] req, input logic [2:0] ptr);
    logic [3:0] sum;
    logic       found;
    rr_pick = 3'd0;
    found   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sum = {1'b0, ptr} + 4'(k);
      if (sum >= 4'd5) sum = sum - 4'd5;
      if (!found && req[sum[2:0]]) begin
        rr_pick = sum[2:0];
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [4:0] onehot5(input logic [2:0] idx);
    onehot5 = 5'b00001 << idx;
  endfunction

  function automatic logic [7:0] flit_mux(input logic [39:0] bus, input logic [2:0] sel);
    case (sel)
      3'd0:    flit_mux = bus[7:0];
      3'd1:    flit_mux = bus[15:8];
      3'd2:    flit_mux = bus[23:16];
      3'd3:    flit_mux = bus[31:24];
      3'd4:    flit_mux = bus[39:32];
      default: flit_mux = 8'd0;
    endcase
  endfunction

  assign w_pick = rr_pick(i_req, r_ptr);
  assign w_read = |w_rd;
  assign w_tail = w_read && (r_cnt == LP_LAST);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state logic; a started packet always runs to its tail read.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (|i_req) w_state_nxt = ST_XFER; else w_state_nxt = ST_IDLE;
      ST_XFER: if (w_tail || w_wd_fire) w_state_nxt = ST_IDLE; else w_state_nxt = ST_XFER;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: read the granted FIFO only when it has data and a credit exists.
  always_comb begin
    w_rd = 5'd0;
    if (r_state == ST_XFER && r_credits != 4'd0) w_rd = r_gnt & i_avail;
    else                                         w_rd = 5'd0;
  end

  // Grant, round-robin pointer and per-packet flit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt  <= 5'd0;
      r_gidx <= 3'd0;
      r_ptr  <= 3'd0;
      r_cnt  <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|i_req) begin
            r_gnt  <= onehot5(w_pick);
            r_gidx <= w_pick;
            // Just-served input becomes lowest priority next time.
            r_ptr  <= (w_pick == 3'd4) ? 3'd0 : w_pick + 3'd1;
            r_cnt  <= 4'd0;
          end
        end
        ST_XFER: begin
          if (w_tail || w_wd_fire) begin
            r_gnt <= 5'd0;
            r_cnt <= 4'd0;
          end else if (w_read) begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_gnt <= 5'd0;
          r_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Credit counter: a read consumes, a return refunds; both together cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits <= LP_CRED;
      r_cr_err  <= 1'b0;
    end else begin
      case ({w_read, i_credit_ret})
        2'b10:   r_credits <= r_credits - 4'd1;
        2'b01: begin
          if (r_credits == LP_CRED) r_cr_err  <= 1'b1;
          else                      r_credits <= r_credits + 4'd1;
        end
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Two-stage datapath: remember which FIFO was read, capture its data a cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel       <= 3'd0;
      r_sel_vld   <= 1'b0;
      r_out_flit  <= 8'd0;
      r_out_valid <= 1'b0;
    end else begin
      r_sel_vld   <= w_read;
      r_out_valid <= r_sel_vld;
      if (w_read)    r_sel      <= r_gidx;
      if (r_sel_vld) r_out_flit <= flit_mux(i_in_flit, r_sel);
    end
  end

`ifdef STALL_WATCHDOG_EN
  localparam int LP_SW = $clog2(WD_LIMIT + 1);

  logic [LP_SW-1:0] r_stall;
  logic             r_wd_err;

  // Fires on the WD_LIMIT-th consecutive XFER cycle without a read.
  assign w_wd_fire = (r_state == ST_XFER) && !w_read && (r_stall == LP_SW'(WD_LIMIT - 1));

  // Stall counter and sticky watchdog flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall  <= '0;
      r_wd_err <= 1'b0;
    end else begin
      if (r_state == ST_XFER && !w_read && !w_wd_fire) r_stall <= r_stall + 1'b1;
      else                                             r_stall <= '0;
      if (w_wd_fire) r_wd_err <= 1'b1;
    end
  end

  assign o_wd_err = r_wd_err;
`else
  assign w_wd_fire = 1'b0;
  assign o_wd_err  = 1'b0;
`endif

  assign o_rd        = w_rd;
  assign o_out_flit  = r_out_flit;
  assign o_out_valid = r_out_valid;
  assign o_gnt       = r_gnt;
  assign o_busy      = (r_state == ST_XFER);
  assign o_credits   = r_credits;
  assign o_cr_err    = r_cr_err;

endmodule

// File: tb/tb_noc_outport_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_outport_arbiter
//   Directed bench for noc_outport_arbiter. A behavioural FIFO model per input
//   presents flit 8'h10*(i+1)+n on the n-th read of input i, one cycle after
//   the read strobe. Inputs change 1 time unit after a rising edge; outputs are
//   sampled away from the edge.
// -----------------------------------------------------------------------------
module tb_noc_outport_arbiter;

  logic        clk;
  logic        rst;
  logic [4:0]  req;
  logic [4:0]  avail;
  logic [39:0] in_flit;
  logic        credit_ret;
  logic [4:0]  rd;
  logic [7:0]  out_flit;
  logic        out_valid;
  logic [4:0]  gnt;
  logic        busy;
  logic [3:0]  credits;
  logic        cr_err;
  logic        wd_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] fifo_cnt [5];

  noc_outport_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_req        (req),
    .i_avail      (avail),
    .i_in_flit    (in_flit),
    .i_credit_ret (credit_ret),
    .o_rd         (rd),
    .o_out_flit   (out_flit),
    .o_out_valid  (out_valid),
    .o_gnt        (gnt),
    .o_busy       (busy),
    .o_credits    (credits),
    .o_cr_err     (cr_err),
    .o_wd_err     (wd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: a read in cycle T exposes the next flit in T+1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flit <= 40'd0;
      for (int i = 0; i < 5; i++) fifo_cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (rd[i]) begin
          in_flit[8*i +: 8] <= 8'((i + 1) * 16) + fifo_cnt[i];
          fifo_cnt[i]       <= fifo_cnt[i] + 8'd1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] eg;
    rst = 1'b1; req = 5'd0; avail = 5'd0; credit_ret = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_flit", 32'(out_flit), 32'h0);
    chk("rst_credits", 32'(credits), 32'd8);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cr_err", 32'(cr_err), 32'h0);
    chk("rst_wd_err", 32'(wd_err), 32'h0);

    // Single 4-flit packet from input 0.
    req = 5'b00001; avail = 5'b00001;
    #1 chk("p1_idle_rd", 32'(rd), 32'h0);
    tick; req = 5'd0; #1;
    chk("p1_gnt", 32'(gnt), 32'h01);
    chk("p1_busy", 32'(busy), 32'h1);
    chk("p1_rd0", 32'(rd), 32'h01);
    tick; chk("p1_rd1", 32'(rd), 32'h01);
    tick; chk("p1_rd2", 32'(rd), 32'h01);
    chk("p1_v0", 32'(out_valid), 32'h1);
    chk("p1_f0", 32'(out_flit), 32'h10);
    tick; chk("p1_rd3", 32'(rd), 32'h01);
    chk("p1_cred5", 32'(credits), 32'd5);
    chk("p1_f1", 32'(out_flit), 32'h11);
    tick; chk("p1_gnt_rel", 32'(gnt), 32'h0);
    chk("p1_busy_rel", 32'(busy), 32'h0);
    chk("p1_cred4", 32'(credits), 32'd4);
    chk("p1_rd_idle", 32'(rd), 32'h0);
    chk("p1_f2", 32'(out_flit), 32'h12);
    tick; chk("p1_f3", 32'(out_flit), 32'h13);
    chk("p1_v3", 32'(out_valid), 32'h1);
    tick; chk("p1_v_end", 32'(out_valid), 32'h0);
    avail = 5'd0;

    // Refill credits to 8 while idle.
    credit_ret = 1'b1;
    repeat (4) tick;
    credit_ret = 1'b0;
    chk("refill_cred", 32'(credits), 32'd8);
    chk("refill_cr_err", 32'(cr_err), 32'h0);

    // Credit stall: two packets from input 2 exhaust credits, third stalls.
    req = 5'b00100; avail = 5'b00100;
    #1;
    for (int pk = 0; pk < 2; pk++) begin
      chk("cs_idle_gnt", 32'(gnt), 32'h0);
      chk("cs_idle_rd", 32'(rd), 32'h0);
      tick;
      for (int f = 0; f < 4; f++) begin
        chk("cs_gnt", 32'(gnt), 32'h04);
        chk("cs_rd", 32'(rd), 32'h04);
        tick;
      end
    end
    chk("cs_cred0", 32'(credits), 32'd0);
    tick;
    chk("cs_gnt3", 32'(gnt), 32'h04);
    chk("cs_stall_rd", 32'(rd), 32'h0);
    tick;
    chk("cs_hold_gnt", 32'(gnt), 32'h04);
    chk("cs_hold_rd", 32'(rd), 32'h0);
    credit_ret = 1'b1;
    #1 chk("cs_ret_rd", 32'(rd), 32'h0);
    tick; credit_ret = 1'b0; #1;
    chk("cs_cred1", 32'(credits), 32'd1);
    chk("cs_one_rd", 32'(rd), 32'h04);
    tick;
    chk("cs_cred_back0", 32'(credits), 32'd0);
    chk("cs_no_rd", 32'(rd), 32'h0);
    chk("cs_gnt_kept", 32'(gnt), 32'h04);
    tick;
    chk("cs_out_v", 32'(out_valid), 32'h1);
    chk("cs_out_f", 32'(out_flit), 32'h38);
    tick;
    chk("cs_out_v_end", 32'(out_valid), 32'h0);

    // avail drop mid-packet while credits climb to 3, then read + return together.
    avail = 5'd0; credit_ret = 1'b1;
    #1 chk("ad_rd0", 32'(rd), 32'h0);
    tick; chk("ad_rd1", 32'(rd), 32'h0);
    tick; chk("ad_rd2", 32'(rd), 32'h0);
    chk("ad_gnt", 32'(gnt), 32'h04);
    tick; avail = 5'b00100; #1;
    chk("rr_cred3", 32'(credits), 32'd3);
    chk("rr_rd", 32'(rd), 32'h04);
    tick; credit_ret = 1'b0; #1;
    chk("rr_cred_same", 32'(credits), 32'd3);
    chk("rr_rd2", 32'(rd), 32'h04);
    tick;
    chk("rr_cred2", 32'(credits), 32'd2);
    chk("rr_gnt_tail", 32'(gnt), 32'h04);
    chk("rr_rd_tail", 32'(rd), 32'h04);
    chk("rr_f39", 32'(out_flit), 32'h39);
    tick; req = 5'd0; avail = 5'd0;
    chk("rr_gnt_rel", 32'(gnt), 32'h0);
    chk("rr_cred1", 32'(credits), 32'd1);
    tick;
    chk("rr_f3b", 32'(out_flit), 32'h3B);
    chk("rr_v3b", 32'(out_valid), 32'h1);

    // Overflowing credit return sets the sticky error.
    credit_ret = 1'b1;
    repeat (7) tick;
    credit_ret = 1'b0;
    chk("ce_full", 32'(credits), 32'd8);
    chk("ce_clean", 32'(cr_err), 32'h0);
    credit_ret = 1'b1;
    tick; credit_ret = 1'b0;
    chk("ce_set", 32'(cr_err), 32'h1);
    chk("ce_cred8", 32'(credits), 32'd8);
    tick;
    chk("ce_sticky", 32'(cr_err), 32'h1);

    // Reset in the middle of an input-3 packet.
    req = 5'b01000; avail = 5'b01000;
    tick; chk("mr_gnt", 32'(gnt), 32'h08);
    tick; tick;
    chk("mr_pre_v", 32'(out_valid), 32'h1);
    chk("mr_pre_f", 32'(out_flit), 32'h40);
    rst = 1'b1;
    #1;
    chk("mr_gnt0", 32'(gnt), 32'h0);
    chk("mr_v0", 32'(out_valid), 32'h0);
    chk("mr_f0", 32'(out_flit), 32'h0);
    chk("mr_cred8", 32'(credits), 32'd8);
    chk("mr_busy0", 32'(busy), 32'h0);
    chk("mr_cr_err0", 32'(cr_err), 32'h0);
    chk("mr_rd0", 32'(rd), 32'h0);
    req = 5'b11111; avail = 5'b11111;
    tick; rst = 1'b0; #1;

    // Fairness: all inputs requesting, six packets, one bubble between each.
    for (int p = 0; p < 6; p++) begin
      eg = 5'b00001 << (p % 5);
      chk("fr_bubble_gnt", 32'(gnt), 32'h0);
      chk("fr_bubble_rd", 32'(rd), 32'h0);
      chk("fr_bubble_busy", 32'(busy), 32'h0);
      tick;
      for (int f = 0; f < 4; f++) begin
        credit_ret = 1'b1;
        #1;
        chk("fr_gnt", 32'(gnt), 32'(eg));
        chk("fr_rd", 32'(rd), 32'(eg));
        tick;
      end
      credit_ret = 1'b0;
    end
    req = 5'd0; avail = 5'd0;
    chk("fr_cred", 32'(credits), 32'd8);
    chk("fr_cr_err", 32'(cr_err), 32'h0);
    chk("fr_f16", 32'(out_flit), 32'h16);
    tick;
    chk("fr_f17", 32'(out_flit), 32'h17);
    chk("fr_v17", 32'(out_valid), 32'h1);
    tick;
    chk("fr_v_end", 32'(out_valid), 32'h0);

    // Stalled grant: input 2 delivers one flit, then its FIFO runs dry.
    req = 5'b00100; avail = 5'b00100;
    tick; req = 5'd0; #1;
    chk("wd_gnt", 32'(gnt), 32'h04);
    chk("wd_rd", 32'(rd), 32'h04);
    tick; avail = 5'd0; #1;
    chk("wd_stall_rd", 32'(rd), 32'h0);
    repeat (15) tick;
    chk("wd_pre_gnt", 32'(gnt), 32'h04);
    chk("wd_pre_err", 32'(wd_err), 32'h0);
    tick;
`ifdef STALL_WATCHDOG_EN
    chk("wd_err_set", 32'(wd_err), 32'h1);
    chk("wd_gnt0", 32'(gnt), 32'h0);
    chk("wd_busy0", 32'(busy), 32'h0);
    chk("wd_cred7", 32'(credits), 32'd7);
    tick;
    chk("wd_err_sticky", 32'(wd_err), 32'h1);
`else
    chk("wd_off_gnt", 32'(gnt), 32'h04);
    chk("wd_off_busy", 32'(busy), 32'h1);
    chk("wd_off_err", 32'(wd_err), 32'h0);
    chk("wd_off_cred7", 32'(credits), 32'd7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/noc_outport_arbiter.md
Name: noc_outport_arbiter

Overview:
- Output-port controller for one router output in the mesh NoC.
- Shares the output between 5 input FIFOs (0=N, 1=E, 2=S, 3=W, 4=Local) using round-robin arbitration with wormhole packet locking.
- Issues read strobes to the winning input FIFO and forwards its 8-bit flits downstream.
- Uses credit-based flow control sized to the downstream 8-deep FIFO.

Parameters:
- PKT_LEN, 4, flits per packet (fixed); grant released after PKT_LEN reads; legal range 1..15.
- CREDITS, 8, downstream buffer depth; initial and maximum credit count; legal range 1..15.
- WD_LIMIT, 16, stall cycles before watchdog fires (used only with STALL_WATCHDOG_EN).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  5  req[i]=1: input i has a packet head routed to this output.
- avail  in  5  avail[i]=1: input FIFO i holds at least one unread flit.
- in_flit  in  40  FIFO data_out buses, input i on bits [8i+7:8i].
- credit_ret  in  1  one-cycle pulse; downstream freed one slot.
- rd  out  5  one-hot FIFO read strobe, combinational.
- out_flit  out  8  forwarded flit, registered.
- out_valid  out  1  out_flit valid this cycle, registered.
- gnt  out  5  one-hot current grant, registered; 0 when idle.
- busy  out  1  1 while in XFER.
- credits  out  4  current credit count.
- cr_err  out  1  sticky: credit_ret received while credits==CREDITS.
- wd_err  out  1  sticky watchdog flag; constant 0 when the feature is compiled out.

Behaviour:
- Reset (async, any state, including mid-packet):
  - state=IDLE, gnt=0, rd=0, out_flit=0, out_valid=0, credits=CREDITS, rr pointer=0, flit counter=0, cr_err=0, wd_err=0.
  - In-flight pipeline flits are discarded.
- FSM has two states, IDLE and XFER.
- IDLE:
  - If req!=0, pick the first i with req[i]=1, searching from ptr upward, modulo 5.
  - Next cycle: state=XFER, gnt=onehot(i), ptr=(i==4)?0:i+1, flit counter=0.
  - If req==0, remain in IDLE.
  - rd=0 throughout IDLE.
- XFER:
  - rd[g] = gnt[g] & avail[g] & (credits!=0). All other rd bits are 0.
  - Each read increments the flit counter.
  - A read when counter==PKT_LEN-1 is the tail read. Next cycle: state=IDLE, gnt=0.
  - req is ignored during XFER; the grant is never preempted.
- Credits:
  - A read decrements credits; credit_ret increments credits.
  - Read and credit_ret in the same cycle: credits unchanged.
  - credits==0: reads stall and the grant is held.
  - credit_ret with credits==CREDITS and no simultaneous read: credits stay at CREDITS and cr_err is set (sticky until rst).
- Datapath:
  - rd asserted in cycle T; the FIFO presents the flit in T+1.
  - The block registers sel=g and a valid bit at the end of T, and in_flit[sel] at the end of T+1.
  - out_flit/out_valid are visible in T+2, giving a fixed 2-cycle rd-to-out latency.
  - Back-to-back reads produce back-to-back out_valid.
- Packet boundary:
  - Tail read at T, IDLE/arbitration at T+1, first read of the next packet at T+2 at the earliest.
  - This leaves exactly one bubble between packets.
- Round-robin:
  - The pointer moves only on grant.
  - A requester that was just served has lowest priority in the next arbitration.
- avail drop mid-packet: no read that cycle, grant held, counter holds.

Optional Feature:
- Macro: STALL_WATCHDOG_EN.
- Defined:
  - A stall counter increments each XFER cycle with rd==0 and clears on any read or on leaving XFER.
  - When the counter reaches WD_LIMIT, wd_err=1 (sticky) and the FSM force-returns to IDLE with gnt=0.
  - The flit counter clears; credits are unchanged.
- Undefined: no stall counter; wd_err is tied 0; a stalled grant is held indefinitely.

Test Plan:
- Single packet: reset, then req=5'b00001, avail=5'b00001, flits A0..A3 -> gnt=00001 one cycle after req. rd[0] high for 4 consecutive cycles. out_flit=A0..A3 on 4 consecutive cycles starting 2 cycles after the first rd. credits 8->4, then gnt=0.
- Fairness: req=5'b11111 held for 5 packets -> grant order 0,1,2,3,4. Then input 0 again, with one idle cycle between packets.
- Credit stall: CREDITS=8, no credit_ret, two 4-flit packets, then a third request -> credits reach 0 and rd stays 0 with gnt held. One credit_ret pulse gives exactly one rd and credits returns to 0.
- Simultaneous read + credit_ret at credits=3 -> credits stays 3. credit_ret at credits=8 with no read -> cr_err=1 and stays 1.
- Reset mid-packet: assert rst after 2 of 4 flits -> gnt=0, out_valid=0, credits=8 immediately. After release, the next arbitration starts from ptr=0.
- With STALL_WATCHDOG_EN, WD_LIMIT=16: grant input 2, then drop avail[2] after 1 flit -> wd_err=1 after 16 stall cycles, state IDLE, gnt=0.
